// File: rtl/fp_norm_pack.sv
// fp_norm_pack: post-add normalizer/packer for the FP adder datapath.
// Normalizes {carry, hidden, fraction} one bit per cycle, strips the hidden bit, packs IEEE-754.
// Optional build macro FP_ROUND_EN: ties-to-even rounding of the bit dropped by a right shift.
module fp_norm_pack #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic [MANT_W+1:0]       in_mant,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+MANT_W:0]   out_result,
   output logic                    out_ovf,
   output logic                    out_unf
);

   // Exponent is tracked one bit wider than the field so +1/-1 steps never wrap.
   localparam logic [EXP_W:0]    EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
   localparam logic [EXP_W:0]    EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
   localparam logic [MANT_W+1:0] MANT_ONE = {{(MANT_W+1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_NORM, S_OUT} state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_sign;
   logic [EXP_W:0]          r_exp;
   logic [MANT_W+1:0]       r_mant;
   logic                    r_special;
   logic [EXP_W+MANT_W:0]   r_result;
   logic                    r_ovf;
   logic                    r_unf;
`ifdef FP_ROUND_EN
   logic                    r_rnd;
   logic                    w_rnd_nxt;
`endif

   logic                    w_capture;
   logic                    w_done;
   logic                    w_ovf;
   logic                    w_unf;
   logic                    w_zero;
   logic [EXP_W:0]          w_exp_nxt;
   logic [MANT_W+1:0]       w_mant_nxt;
   logic [EXP_W-1:0]        w_res_exp;
   logic [MANT_W-1:0]       w_res_frac;

   assign w_capture = in_valid && in_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic: NORM exits as soon as the datapath reports a terminal action
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_capture)             w_state_nxt = S_NORM;
         S_NORM:  if (w_done)                w_state_nxt = S_OUT;
         S_OUT:   if (out_ready)             w_state_nxt = S_IDLE;
         default:                            w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_OUT);
   end

   // One normalization action per cycle, in priority order
   always_comb begin
      w_done     = 1'b0;
      w_ovf      = 1'b0;
      w_unf      = 1'b0;
      w_zero     = 1'b0;
      w_exp_nxt  = r_exp;
      w_mant_nxt = r_mant;
`ifdef FP_ROUND_EN
      w_rnd_nxt  = 1'b0;
`endif
      if (r_special) begin
         w_done = 1'b1;
`ifdef FP_ROUND_EN
      end else if (r_rnd) begin
         // Deferred round-up; a carry out is picked up by the right-shift rule next cycle
         w_mant_nxt = r_mant + MANT_ONE;
`endif
      end else if (r_mant == '0) begin
         w_done = 1'b1;
         w_zero = 1'b1;
      end else if (r_mant[MANT_W+1]) begin
         w_mant_nxt = r_mant >> 1;
         w_exp_nxt  = r_exp + EXP_ONE;
         if (w_exp_nxt == EXP_MAX) begin
            w_done = 1'b1;
            w_ovf  = 1'b1;
         end
`ifdef FP_ROUND_EN
         // Guard is the dropped bit; round only on a tie with an odd result
         else w_rnd_nxt = r_mant[0] & r_mant[1];
`endif
      end else if (r_mant[MANT_W]) begin
         w_done = 1'b1;
      end else if (r_exp <= EXP_ONE) begin
         // Another left shift would need exponent 0: flush instead of going subnormal
         w_done = 1'b1;
         w_unf  = 1'b1;
      end else begin
         w_mant_nxt = r_mant << 1;
         w_exp_nxt  = r_exp - EXP_ONE;
      end
   end

   // Packed result fields for the terminal cycle
   always_comb begin
      w_res_exp  = r_exp[EXP_W-1:0];
      w_res_frac = r_mant[MANT_W-1:0];
      if (w_ovf) begin
         w_res_exp  = '1;
         w_res_frac = '0;
      end else if (w_unf || w_zero) begin
         w_res_exp  = '0;
         w_res_frac = '0;
      end
   end

   // Operand capture, per-cycle datapath update and result/flag registration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign    <= 1'b0;
         r_exp     <= '0;
         r_mant    <= '0;
         r_special <= 1'b0;
         r_result  <= '0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
`ifdef FP_ROUND_EN
         r_rnd     <= 1'b0;
`endif
      end else if (w_capture) begin
         r_sign    <= in_sign;
         r_exp     <= {1'b0, in_exp};
         r_mant    <= in_mant;
         r_special <= &in_exp;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
`ifdef FP_ROUND_EN
         r_rnd     <= 1'b0;
`endif
      end else if (r_state == S_NORM) begin
         if (w_done) begin
            r_result <= {r_sign, w_res_exp, w_res_frac};
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
         end else begin
            r_exp    <= w_exp_nxt;
            r_mant   <= w_mant_nxt;
         end
`ifdef FP_ROUND_EN
         r_rnd <= w_rnd_nxt;
`endif
      end
   end

   assign out_result = r_result;
   assign out_ovf    = r_ovf;
   assign out_unf    = r_unf;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Bench for fp_norm_pack: scoreboard of expected {result, flags, latency} per operand.
// Directed operands carry hand-derived expectations; random ones use a behavioural model.
module tb_fp_norm_pack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [7:0]  in_exp = '0;
   logic [24:0] in_mant = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic        out_ovf;
   logic        out_unf;

   fp_norm_pack #(.EXP_W(8), .MANT_W(23)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      int          lat;
      int          cap;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   first_vld_cyc = 0;
   logic prev_vld = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: latency counts the capture cycle plus every NORM cycle
   function automatic exp_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
      exp_t r;
      int   ex = e;
      int   ncyc = 0;
      logic [24:0] mm = m;
      logic g;
      r.ovf = 1'b0; r.unf = 1'b0; r.cap = 0;
      if (e == 8'hFF) begin
         r.res = {s, e, m[22:0]}; r.lat = 2; return r;
      end
      if (m == '0) begin
         r.res = {s, 31'd0}; r.lat = 2; return r;
      end
      while (mm[24]) begin
         g = mm[0]; mm = mm >> 1; ex++; ncyc++;
         if (ex == 255) begin
            r.ovf = 1'b1; r.res = {s, 8'hFF, 23'd0}; r.lat = 1 + ncyc; return r;
         end
`ifdef FP_ROUND_EN
         if (g && mm[0]) begin mm = mm + 25'd1; ncyc++; end
`else
         if (g) begin end
`endif
      end
      while (!mm[23]) begin
         ncyc++;
         if (ex <= 1) begin
            r.unf = 1'b1; r.res = {s, 31'd0}; r.lat = 1 + ncyc; return r;
         end
         mm = mm << 1; ex--;
      end
      ncyc++;
      r.res = {s, 8'(ex), mm[22:0]};
      r.lat = 1 + ncyc;
      return r;
   endfunction

   function automatic exp_t mk(input logic [31:0] res, input logic ovf, input logic unf, input int lat);
      exp_t r;
      r.res = res; r.ovf = ovf; r.unf = unf; r.lat = lat; r.cap = 0;
      return r;
   endfunction

   // Drive one operand; push its expectation once the capture edge has happened
   task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                       input exp_t x, input bit push);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin @(negedge clk); w++; end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x.cap = cyc;
      if (push) sb.push_back(x);
   endtask

   task automatic drain();
      int w = 0;
      while (sb.size() != 0 && w < 2000) begin @(negedge clk); w++; end
      if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
   endtask

   // Monitor: track first valid cycle, pop and compare on each handshake
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !prev_vld) first_vld_cyc = cyc;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("result", 64'(out_result), 64'(x.res));
               chk("ovf", 64'(out_ovf), 64'(x.ovf));
               chk("unf", 64'(out_unf), 64'(x.unf));
               chk("latency", 64'(first_vld_cyc - x.cap + 1), 64'(x.lat));
            end
         end
      end
      prev_vld = out_valid;
   end

   initial begin
      logic [31:0] snap;
      logic        snap_ovf;
      int          w;
      int          seen;
      logic [7:0]  re;
      logic [24:0] rm;
      logic        rs;

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_result", 64'(out_result), 0);
      chk("rst_ovf", 64'(out_ovf), 0);
      chk("rst_unf", 64'(out_unf), 0);
      rst_n = 1'b1;

      // Directed operands with hand-derived expectations
      send(0, 8'h7F, 25'h0800000, mk(32'h3F800000, 0, 0, 2), 1);
      send(0, 8'h7F, 25'h1000000, mk(32'h40000000, 0, 0, 3), 1);
      send(0, 8'h85, 25'h0000001, mk(32'h37000000, 0, 0, 25), 1);
      send(1, 8'h02, 25'h0200000, mk(32'h80000000, 0, 1, 3), 1);
      send(0, 8'hFE, 25'h1000000, mk(32'h7F800000, 1, 0, 2), 1);
`ifdef FP_ROUND_EN
      send(0, 8'h7F, 25'h1000003, mk(32'h40000002, 0, 0, 4), 1);
      send(0, 8'h7F, 25'h1FFFFFF, mk(32'h40800000, 0, 0, 5), 1);
`else
      send(0, 8'h7F, 25'h1000003, mk(32'h40000001, 0, 0, 3), 1);
      send(0, 8'h7F, 25'h1FFFFFF, mk(32'h407FFFFF, 0, 0, 3), 1);
`endif
      send(0, 8'hFF, 25'h0400001, mk(32'h7FC00001, 0, 0, 2), 1);
      send(1, 8'h50, 25'h0000000, mk(32'h80000000, 0, 0, 2), 1);
      send(1, 8'h01, 25'h0400000, mk(32'h80000000, 0, 1, 2), 1);
      drain();

      // Random operands against the model
      for (int i = 0; i < 24; i++) begin
         rs = 1'($urandom);
         re = 8'($urandom_range(30, 200));
         case ($urandom_range(0, 2))
            0:       rm = {1'b1, 24'($urandom)};
            1:       rm = {2'b01, 23'($urandom)};
            default: rm = (25'($urandom) & 25'h7FFFFF) >> $urandom_range(0, 22) | 25'd1;
         endcase
         send(rs, re, rm, model(rs, re, rm), 1);
      end
      drain();

      // Output stall: result and flags hold, no new capture
      out_ready = 1'b0;
      send(0, 8'hFE, 25'h1000000, mk(32'h7F800000, 1, 0, 2), 1);
      w = 0;
      while (!out_valid && w < 100) begin @(negedge clk); w++; end
      chk("stall_valid", 64'(out_valid), 1);
      snap = out_result;
      snap_ovf = out_ovf;
      chk("stall_snap", 64'(snap), 64'h7F800000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_result", 64'(out_result), 64'(snap));
         chk("stall_ovf", 64'(out_ovf), 64'(snap_ovf));
         chk("stall_in_ready", 64'(in_ready), 0);
         chk("stall_out_valid", 64'(out_valid), 1);
      end
      out_ready = 1'b1;
      drain();

      // Reset during NORM aborts the operand with no output
      send(0, 8'h85, 25'h0000001, mk(32'h0, 0, 0, 0), 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 64'(in_ready), 1);
      chk("abort_out_valid", 64'(out_valid), 0);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_output", 64'(seen), 0);

      // Normal operation resumes after the abort
      send(0, 8'h7F, 25'h0800000, mk(32'h3F800000, 0, 0, 2), 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
